// File: rtl/lsu_pipelined.sv
// lsu_pipelined: multi-cycle RV load/store unit with a valid/grant memory port,
// lane-aligned byte enables/store data and a registered writeback or exception.
module lsu_pipelined #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   localparam int OFF_W = $clog2(DATA_WIDTH/8)
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [31:0]             inst_i,
   input  logic [DATA_WIDTH-1:0]   op1_i,
   input  logic [DATA_WIDTH-1:0]   op2_i,
   input  logic                    flush_i,
   output logic                    mem_req_o,
   input  logic                    mem_gnt_i,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic                    mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_err_i,
   output logic                    wb_valid_o,
   output logic                    reg_we_o,
   output logic [DATA_WIDTH-1:0]   reg_wdata_o,
   output logic                    exc_o,
   output logic [3:0]              exc_cause_o
);
   localparam int BW = DATA_WIDTH/8;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;
   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [BW-1:0]           be_q;
   logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
   logic                    we_q, uns_q, rwe_q, exc_q;
   logic [1:0]              size_q;
   logic [3:0]              cause_q;
   logic [2:0]              f3;
   logic                    is_ld, is_st, legal, misal, wb;
   logic [11:0]             imm;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic [OFF_W-1:0]        off;
   logic [7:0]              szm;
   logic [15:0]             be_d;
   logic [DATA_WIDTH-1:0]   wdata_d, sh, ld_d;
   always_comb begin
      f3      = inst_i[14:12];
      is_ld   = inst_i[6:0] == 7'h03;
      is_st   = inst_i[6:0] == 7'h23;
      legal   = (is_ld && f3 != 3'd7 && (DATA_WIDTH == 64 || (f3[1:0] != 2'd3 && f3 != 3'd6))) ||
                (is_st && !f3[2] && (DATA_WIDTH == 64 || f3[1:0] != 2'd3));
      imm     = is_st ? {inst_i[31:25], inst_i[11:7]} : inst_i[31:20];
      addr_d  = op1_i[ADDR_WIDTH-1:0] + ADDR_WIDTH'($signed(imm));
      off     = addr_d[OFF_W-1:0];
      misal   = (f3[1:0] == 2'd1 && addr_d[0]) || (f3[1:0] == 2'd2 && |addr_d[1:0]) ||
                (f3[1:0] == 2'd3 && |addr_d[2:0]);
      szm     = f3[1:0] == 2'd0 ? 8'h01 : f3[1:0] == 2'd1 ? 8'h03 : f3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
      be_d    = {8'h00, szm} << off;
      wdata_d = op2_i << {off, 3'b000};
      // Unsigned loads clear the extension bit so the signed cast zero-fills.
      sh      = mem_rdata_i >> {addr_q[OFF_W-1:0], 3'b000};
      ld_d    = size_q == 2'd0 ? DATA_WIDTH'($signed({~uns_q & sh[7], sh[7:0]})) :
                size_q == 2'd1 ? DATA_WIDTH'($signed({~uns_q & sh[15], sh[15:0]})) :
                size_q == 2'd2 ? DATA_WIDTH'($signed({~uns_q & sh[31], sh[31:0]})) : sh;
      wb      = state_q == DONE && !flush_i;
   end
   assign req_ready_o = state_q == IDLE;
   assign mem_req_o   = state_q == REQ;
   assign mem_addr_o  = mem_req_o ? {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign mem_we_o    = mem_req_o && we_q;
   assign mem_be_o    = mem_req_o ? be_q : '0;
   assign mem_wdata_o = mem_req_o ? wdata_q : '0;
   assign wb_valid_o  = wb;
   assign reg_we_o    = wb && rwe_q;
   assign reg_wdata_o = wb ? rdata_q : '0;
   assign exc_o       = wb && exc_q;
   assign exc_cause_o = wb && exc_q ? cause_q : 4'd0;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'd0;
         rwe_q   <= 1'b0;
         rdata_q <= '0;
         exc_q   <= 1'b0;
         cause_q <= 4'd0;
      end else begin
         case (state_q)
            IDLE: if (req_valid_i && !flush_i) begin
               addr_q  <= addr_d;
               be_q    <= be_d[BW-1:0];
               wdata_q <= wdata_d;
               we_q    <= is_st;
               size_q  <= f3[1:0];
               uns_q   <= f3[2];
               rwe_q   <= 1'b0;
               rdata_q <= '0;
               exc_q   <= !legal || misal;
               cause_q <= !legal ? 4'd2 : is_st ? 4'd6 : 4'd4;
               state_q <= (!legal || misal) ? DONE : REQ;
            end
            REQ: state_q <= flush_i ? IDLE : mem_gnt_i ? WAIT : REQ;
            WAIT: if (flush_i) state_q <= mem_rvalid_i ? IDLE : DRAIN;
               else if (mem_rvalid_i) begin
                  state_q <= DONE;
                  exc_q   <= mem_err_i;
                  cause_q <= we_q ? 4'd7 : 4'd5;
                  rwe_q   <= !we_q && !mem_err_i;
                  rdata_q <= (!we_q && !mem_err_i) ? ld_d : '0;
               end
            DRAIN: if (mem_rvalid_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_pipelined.sv
// tb_lsu_pipelined: directed checks of lsu_pipelined at DATA_WIDTH 32 and 64.
module tb_lsu_pipelined;
   logic clk_i = 1'b0, rst_n_i = 1'b0;
   always #5 clk_i = ~clk_i;
   logic        req_valid, req_ready, flush, mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
   logic        wb_valid, reg_we, exc;
   logic [31:0] inst, op1, op2, mem_addr, mem_wdata, mem_rdata, reg_wdata;
   logic [3:0]  mem_be, exc_cause;
   logic        req_valid6, req_ready6, flush6, mem_req6, mem_gnt6, mem_we6, mem_rvalid6, mem_err6;
   logic        wb_valid6, reg_we6, exc6;
   logic [31:0] inst6, mem_addr6;
   logic [63:0] op16, op26, mem_wdata6, mem_rdata6, reg_wdata6;
   logic [7:0]  mem_be6;
   logic [3:0]  exc_cause6;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   int total = 0, fails = 0;

   lsu_pipelined dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .inst_i(inst), .op1_i(op1), .op2_i(op2), .flush_i(flush), .mem_req_o(mem_req),
      .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .mem_err_i(mem_err), .wb_valid_o(wb_valid), .reg_we_o(reg_we), .reg_wdata_o(reg_wdata),
      .exc_o(exc), .exc_cause_o(exc_cause));

   lsu_pipelined #(.DATA_WIDTH(64)) dut64 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid6), .req_ready_o(req_ready6),
      .inst_i(inst6), .op1_i(op16), .op2_i(op26), .flush_i(flush6), .mem_req_o(mem_req6),
      .mem_gnt_i(mem_gnt6), .mem_addr_o(mem_addr6), .mem_we_o(mem_we6), .mem_be_o(mem_be6),
      .mem_wdata_o(mem_wdata6), .mem_rvalid_i(mem_rvalid6), .mem_rdata_i(mem_rdata6),
      .mem_err_i(mem_err6), .wb_valid_o(wb_valid6), .reg_we_o(reg_we6), .reg_wdata_o(reg_wdata6),
      .exc_o(exc6), .exc_cause_o(exc_cause6));

   function automatic logic [31:0] mk_ld(input logic [11:0] imm, input logic [2:0] f3);
      return {imm, 5'd1, f3, 5'd2, 7'h03};
   endfunction
   function automatic logic [31:0] mk_st(input logic [11:0] imm, input logic [2:0] f3);
      return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'h23};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Accept in cycle 0, grant after gdly stalled REQ cycles, respond one cycle after grant.
   // Returns in the cycle where the writeback pulse is due.
   task automatic xact(input logic [31:0] i, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input logic err, input int gdly);
      req_valid = 1'b1; inst = i; op1 = a; op2 = d; mem_gnt = (gdly == 0);
      step();
      req_valid = 1'b0;
      chk("req_in_req", {63'd0, mem_req}, 64'd1);
      m_addr = mem_addr; m_be = mem_be; m_wdata = mem_wdata;
      for (int k = 0; k < gdly; k++) begin
         step();
         chk("stall_req", {63'd0, mem_req}, 64'd1);
         chk("stall_addr", {32'd0, mem_addr}, {32'd0, m_addr});
         chk("stall_be", {60'd0, mem_be}, {60'd0, m_be});
         chk("stall_wdata", {32'd0, mem_wdata}, {32'd0, m_wdata});
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("wait_no_req", {63'd0, mem_req}, 64'd0);
      chk("wait_no_wb", {63'd0, wb_valid}, 64'd0);
      mem_rvalid = 1'b1; mem_rdata = rd; mem_err = err;
      step();
      mem_rvalid = 1'b0; mem_err = 1'b0;
   endtask

   task automatic x64(input logic [31:0] i, input logic [63:0] a, input logic [63:0] rd,
                      input logic [7:0] be, input logic [63:0] res);
      req_valid6 = 1'b1; inst6 = i; op16 = a; mem_gnt6 = 1'b1;
      step();
      req_valid6 = 1'b0;
      chk("d64_req", {63'd0, mem_req6}, 64'd1);
      chk("d64_addr", {32'd0, mem_addr6}, 64'h8);
      chk("d64_be", {56'd0, mem_be6}, {56'd0, be});
      step();
      mem_gnt6 = 1'b0; mem_rvalid6 = 1'b1; mem_rdata6 = rd;
      step();
      mem_rvalid6 = 1'b0;
      chk("d64_wb", {63'd0, wb_valid6}, 64'd1);
      chk("d64_we", {63'd0, reg_we6}, 64'd1);
      chk("d64_data", reg_wdata6, res);
      step();
   endtask

   initial begin
      req_valid = 0; inst = 0; op1 = 0; op2 = 0; flush = 0; mem_gnt = 0;
      mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
      req_valid6 = 0; inst6 = 0; op16 = 0; op26 = 0; flush6 = 0; mem_gnt6 = 0;
      mem_rvalid6 = 0; mem_rdata6 = 0; mem_err6 = 0;
      #2;
      chk("rst_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_req", {63'd0, mem_req}, 64'd0);
      chk("rst_wb", {63'd0, wb_valid}, 64'd0);
      #10 rst_n_i = 1'b1;
      step();
      // LW 0x1004, zero-wait
      xact(mk_ld(12'h004, 3'd2), 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0, 0);
      chk("lw_addr", {32'd0, m_addr}, 64'h1004);
      chk("lw_be", {60'd0, m_be}, 64'hF);
      chk("lw_wb", {63'd0, wb_valid}, 64'd1);
      chk("lw_we", {63'd0, reg_we}, 64'd1);
      chk("lw_data", {32'd0, reg_wdata}, 64'hDEADBEEF);
      chk("lw_exc", {63'd0, exc}, 64'd0);
      step();
      chk("lw_pulse_end", {63'd0, wb_valid}, 64'd0);
      chk("lw_ready", {63'd0, req_ready}, 64'd1);
      // LB / LBU at 0x1003
      xact(mk_ld(12'h003, 3'd0), 32'h1000, 32'h0, 32'h80112233, 1'b0, 0);
      chk("lb_addr", {32'd0, m_addr}, 64'h1000);
      chk("lb_be", {60'd0, m_be}, 64'h8);
      chk("lb_data", {32'd0, reg_wdata}, 64'hFFFFFF80);
      step();
      xact(mk_ld(12'h003, 3'd4), 32'h1000, 32'h0, 32'h80112233, 1'b0, 0);
      chk("lbu_data", {32'd0, reg_wdata}, 64'h00000080);
      step();
      // SH at 0x2002 with three stalled grant cycles
      xact(mk_st(12'h002, 3'd1), 32'h2000, 32'h0000ABCD, 32'h0, 1'b0, 3);
      chk("sh_addr", {32'd0, m_addr}, 64'h2000);
      chk("sh_be", {60'd0, m_be}, 64'hC);
      chk("sh_wdata", {32'd0, m_wdata}, 64'hABCD0000);
      chk("sh_wb", {63'd0, wb_valid}, 64'd1);
      chk("sh_we", {63'd0, reg_we}, 64'd0);
      chk("sh_wdata_zero", {32'd0, reg_wdata}, 64'd0);
      step();
      // SW store error
      xact(mk_st(12'h000, 3'd2), 32'h3000, 32'h12345678, 32'h0, 1'b1, 0);
      chk("sw_be", {60'd0, m_be}, 64'hF);
      chk("sw_wdata", {32'd0, m_wdata}, 64'h12345678);
      chk("sw_exc", {63'd0, exc}, 64'd1);
      chk("sw_cause", {60'd0, exc_cause}, 64'd7);
      step();
      // Load access error
      xact(mk_ld(12'h000, 3'd2), 32'h1000, 32'h0, 32'h55555555, 1'b1, 0);
      chk("lerr_wb", {63'd0, wb_valid}, 64'd1);
      chk("lerr_exc", {63'd0, exc}, 64'd1);
      chk("lerr_cause", {60'd0, exc_cause}, 64'd5);
      chk("lerr_we", {63'd0, reg_we}, 64'd0);
      step();
      // Misaligned LW at 0x1002: DONE in cycle 1, no memory request
      req_valid = 1'b1; inst = mk_ld(12'h002, 3'd2); op1 = 32'h1000;
      step();
      req_valid = 1'b0;
      chk("mis_req", {63'd0, mem_req}, 64'd0);
      chk("mis_wb", {63'd0, wb_valid}, 64'd1);
      chk("mis_exc", {63'd0, exc}, 64'd1);
      chk("mis_cause", {60'd0, exc_cause}, 64'd4);
      step();
      // Misaligned SW at 0x3001
      req_valid = 1'b1; inst = mk_st(12'h001, 3'd2); op1 = 32'h3000;
      step();
      req_valid = 1'b0;
      chk("smis_cause", {60'd0, exc_cause}, 64'd6);
      step();
      // Illegal opcode and LD on the 32-bit unit
      req_valid = 1'b1; inst = 32'h00208033;
      step();
      req_valid = 1'b0;
      chk("ill_op_req", {63'd0, mem_req}, 64'd0);
      chk("ill_op_cause", {60'd0, exc_cause}, 64'd2);
      step();
      req_valid = 1'b1; inst = mk_ld(12'h000, 3'd3); op1 = 32'h1000;
      step();
      req_valid = 1'b0;
      chk("ill_ld_exc", {63'd0, exc}, 64'd1);
      chk("ill_ld_cause", {60'd0, exc_cause}, 64'd2);
      step();
      // Flush in DONE suppresses the pulse
      req_valid = 1'b1; inst = mk_ld(12'h002, 3'd2); op1 = 32'h1000;
      step();
      req_valid = 1'b0; flush = 1'b1;
      #1;
      chk("fdone_wb", {63'd0, wb_valid}, 64'd0);
      chk("fdone_exc", {63'd0, exc}, 64'd0);
      flush = 1'b0;
      step();
      // Flush in REQ withdraws the request; request under flush is refused
      req_valid = 1'b1; inst = mk_ld(12'h000, 3'd2); op1 = 32'h1000;
      step();
      req_valid = 1'b0; flush = 1'b1;
      step();
      chk("freq_idle", {63'd0, req_ready}, 64'd1);
      chk("freq_noreq", {63'd0, mem_req}, 64'd0);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0; flush = 1'b0;
      chk("fblock_idle", {63'd0, req_ready}, 64'd1);
      chk("fblock_noreq", {63'd0, mem_req}, 64'd0);
      // Flush in WAIT drains the late response without a pulse
      req_valid = 1'b1; inst = mk_ld(12'h000, 3'd2); op1 = 32'h1000; mem_gnt = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      mem_gnt = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fwait_busy", {63'd0, req_ready}, 64'd0);
      chk("fwait_wb0", {63'd0, wb_valid}, 64'd0);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
      step();
      mem_rvalid = 1'b0;
      chk("fwait_wb1", {63'd0, wb_valid}, 64'd0);
      chk("fwait_ready", {63'd0, req_ready}, 64'd1);
      // Asynchronous reset while in REQ
      req_valid = 1'b1; inst = mk_st(12'h004, 3'd2); op1 = 32'h4000; op2 = 32'hCAFEF00D;
      step();
      req_valid = 1'b0;
      chk("rreq_req", {63'd0, mem_req}, 64'd1);
      rst_n_i = 1'b0;
      #1;
      chk("rreq_req0", {63'd0, mem_req}, 64'd0);
      chk("rreq_addr0", {32'd0, mem_addr}, 64'd0);
      chk("rreq_be0", {60'd0, mem_be}, 64'd0);
      chk("rreq_wdata0", {32'd0, mem_wdata}, 64'd0);
      chk("rreq_we0", {63'd0, mem_we}, 64'd0);
      chk("rreq_ready", {63'd0, req_ready}, 64'd1);
      #1 rst_n_i = 1'b1;
      mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
      chk("rreq_stray", {63'd0, wb_valid}, 64'd0);
      step();
      // 64-bit unit: LD at 0x8 and sign-extended LW from the upper lane
      x64(mk_ld(12'h000, 3'd3), 64'h8, 64'hFEDCBA9876543210, 8'hFF, 64'hFEDCBA9876543210);
      x64(mk_ld(12'h004, 3'd2), 64'h8, 64'hF000000100000000, 8'hF0, 64'hFFFFFFFFF0000001);
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule

// File: doc/lsu_pipelined.md
Name: lsu_pipelined

Overview:
- Multi-cycle load/store unit for the execute stage; successor to the combinational S/L-type executor.
- Decodes every RV load/store funct3: LB/LH/LW/LBU/LHU/SB/SH/SW, plus LD/LWU/SD when DATA_WIDTH=64.
- Computes the effective address, then drives a valid/grant memory request with byte enables and lane-aligned store data.
- Waits for the read/write response, sign- or zero-extends load data, and returns a registered writeback or a misalign/access exception to the pipeline.

Parameters:
DATA_WIDTH, 32, register/bus width; legal values 32 or 64.
ADDR_WIDTH, 32, memory address width.
OFF_W, $clog2(DATA_WIDTH/8), low address bits that select the byte lane (derived; do not override).

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  asynchronous active-low reset.
req_valid_i  in  1  execute stage presents a load/store instruction.
req_ready_o  out  1  unit is IDLE and can accept an instruction.
inst_i  in  32  instruction word; opcode [6:0], funct3 [14:12].
op1_i  in  DATA_WIDTH  rs1 value (base address).
op2_i  in  DATA_WIDTH  rs2 value (store data).
flush_i  in  1  kill the in-flight instruction.
mem_req_o  out  1  memory request valid.
mem_gnt_i  in  1  memory accepts the request.
mem_addr_o  out  ADDR_WIDTH  word-aligned address (low OFF_W bits forced to 0).
mem_we_o  out  1  1 = store.
mem_be_o  out  DATA_WIDTH/8  byte enables.
mem_wdata_o  out  DATA_WIDTH  store data shifted into its byte lanes.
mem_rvalid_i  in  1  response valid, one per granted request.
mem_rdata_i  in  DATA_WIDTH  load data.
mem_err_i  in  1  bus error, qualified by mem_rvalid_i.
wb_valid_o  out  1  one-cycle completion pulse.
reg_we_o  out  1  write rd; 1 only for a completed load.
reg_wdata_o  out  DATA_WIDTH  extended load result.
exc_o  out  1  exception pulse; coincides with wb_valid_o.
exc_cause_o  out  4  4 = load misaligned, 5 = load access, 6 = store misaligned, 7 = store access, 2 = illegal.

Behaviour:
- Reset: rst_n_i low asynchronously forces state IDLE and all outputs to 0, except req_ready_o=1. This also applies mid-transaction; an outstanding response arriving after reset is ignored.
- FSM states:
  - IDLE, with req_ready_o=1.
  - REQ: mem_req_o=1. Addr, we, be and wdata are held stable until mem_gnt_i.
  - WAIT: mem_req_o=0, waiting for mem_rvalid_i.
  - DONE: wb_valid_o=1 for exactly one cycle, then IDLE.
- Accept: on req_valid_i & req_ready_o in IDLE, register the address and decoded fields.
  - Store address = op1_i + sext(inst[31:25],inst[11:7]).
  - Load address = op1_i + sext(inst[31:20]).
  - Arithmetic is modulo 2^ADDR_WIDTH, so wrap-around is silent.
- Opcode not load/store, or funct3 not legal for DATA_WIDTH: go directly to DONE with exc_o=1, cause 2. No memory access.
- Alignment rules: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0. Violation: DONE with cause 4 or 6, no memory access.
- Byte enables: size mask (B=1, H=3, W=F, D=FF) shifted left by addr[OFF_W-1:0].
- Store data: op2_i low bytes shifted left by 8*offset.
- Load data: select the bytes of mem_rdata_i at the offset, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU/LD).
- REQ→WAIT on mem_gnt_i.
- WAIT→DONE on mem_rvalid_i:
  - Load: reg_we_o=1 with the result.
  - Store: reg_we_o=0, reg_wdata_o=0.
  - mem_err_i=1: exc_o=1, cause 5 or 7, reg_we_o=0.
- Latency with zero-wait memory (gnt in the first REQ cycle, rvalid the next cycle): accept at cycle 0, mem_req_o in cycle 1, rvalid in cycle 2, wb_valid_o in cycle 3. The unit is not pipelined: one outstanding request.
- mem_rvalid_i is ignored outside WAIT.
- flush_i behaviour by state:
  - IDLE or REQ: return to IDLE next cycle. A request not yet granted is withdrawn; no wb pulse.
  - WAIT: move to a drain substate that waits for mem_rvalid_i, then IDLE with no wb pulse.
  - DONE: wb is suppressed.
- A new request presented while flush_i=1 is not accepted.
- Outputs not named as active in a state are 0.

Test Plan:
- LW: op1=0x1000, imm=4, mem rdata=0xDEADBEEF, gnt and rvalid immediate. Expect mem_addr_o=0x1004, be=F, wb_valid_o at cycle 3, reg_wdata_o=0xDEADBEEF, reg_we_o=1.
- LB at 0x1003 with rdata=0x80112233. Expect be=8, reg_wdata_o=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x2002 with op2=0x0000ABCD. Expect be=C, wdata=0xABCD0000, we=1. Hold gnt low 3 cycles: addr/be/wdata stable and mem_req_o held; wb_valid_o with reg_we_o=0.
- LW at 0x1002: no mem_req_o; wb_valid_o+exc_o, cause 4, at cycle 1 after accept.
- Load with mem_err_i=1 on rvalid → exc_o=1, cause 5, reg_we_o=0.
- flush_i asserted in WAIT; rvalid arrives 2 cycles later. No wb_valid_o, req_ready_o=1 afterwards.
- rst_n_i pulsed low in REQ: all outputs 0 immediately, req_ready_o=1.
- DATA_WIDTH=64, LD at 0x8: be=FF, full 64-bit result.
